// File: rtl/register_file_nw_mr_latch.sv
// Latch-based multi-port register file with hardware zero-init sweep, per-byte write enables,
// per-word clock gating behind one global gate, and same-edge write-to-read forwarding.
module register_file_nw_mr_latch #(
   parameter int NUM_WORDS  = 32,
   parameter int ADDR_WIDTH = $clog2(NUM_WORDS),
   parameter int DATA_WIDTH = 32,
   parameter int NUM_WPORTS = 2,
   parameter int NUM_RPORTS = 2
) (
   input  logic                                    clk,
   input  logic                                    rst,
   input  logic                                    test_en_i,
   output logic                                    init_done_o,
   input  logic [NUM_RPORTS-1:0][ADDR_WIDTH-1:0]   raddr_i,
   output logic [NUM_RPORTS-1:0][DATA_WIDTH-1:0]   rdata_o,
   input  logic [NUM_WPORTS-1:0]                   we_i,
   input  logic [NUM_WPORTS-1:0][ADDR_WIDTH-1:0]   waddr_i,
   input  logic [NUM_WPORTS-1:0][DATA_WIDTH-1:0]   wdata_i,
   input  logic [NUM_WPORTS-1:0][DATA_WIDTH/8-1:0] be_i
);

   localparam int                  NB    = DATA_WIDTH / 8;
   localparam logic [ADDR_WIDTH:0]   WORDS = (ADDR_WIDTH + 1)'(NUM_WORDS);
   localparam logic [ADDR_WIDTH-1:0] LAST  = ADDR_WIDTH'(NUM_WORDS - 1);

   typedef enum logic {S_INIT, S_READY} state_t;

   state_t                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
   logic                    init_wr, ready;

   logic [NUM_WPORTS-1:0]   wreq;
   logic [NUM_WPORTS-1:0]   wvld_p1;
   logic [NUM_WPORTS-1:0][ADDR_WIDTH-1:0] waddr_p1;
   logic [NUM_WPORTS-1:0][DATA_WIDTH-1:0] wdata_p1;
   logic [NUM_WPORTS-1:0][NB-1:0]         be_p1;
   logic                    init_vld_p1;
   logic [ADDR_WIDTH-1:0]   init_addr_p1;
   logic [NUM_RPORTS-1:0][ADDR_WIDTH-1:0] raddr_p1;

   logic                    glob_en, glob_en_l, gclk;
   wire  [NUM_WORDS-1:0][DATA_WIDTH-1:0]  mem;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_INIT;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (state_q == S_INIT) begin
         cnt_d = cnt_q + 1'b1;
         if (cnt_q == LAST) begin
            state_d = S_READY;
            cnt_d   = '0;
         end
      end
   end

   always_comb begin
      init_wr     = (state_q == S_INIT);
      ready       = (state_q == S_READY);
      init_done_o = ready;
   end

   // Requests are qualified before the edge so the clock gates can open in the following high phase.
   always_comb begin
      for (int p = 0; p < NUM_WPORTS; p++) begin
         wreq[p] = ready && we_i[p] && ({1'b0, waddr_i[p]} < WORDS) && (|be_i[p]);
      end
   end

   // Stage p1: sampled write requests, init-sweep write and read addresses.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wvld_p1      <= '0;
         waddr_p1     <= '0;
         wdata_p1     <= '0;
         be_p1        <= '0;
         init_vld_p1  <= 1'b0;
         init_addr_p1 <= '0;
         raddr_p1     <= '0;
      end else begin
         wvld_p1      <= wreq;
         waddr_p1     <= waddr_i;
         wdata_p1     <= wdata_i;
         be_p1        <= be_i;
         init_vld_p1  <= init_wr;
         init_addr_p1 <= cnt_q;
         raddr_p1     <= raddr_i;
      end
   end

   assign glob_en = init_wr | (|wreq);

   always_latch begin
      if (!clk) glob_en_l = glob_en | test_en_i;
   end

   assign gclk = clk & glob_en_l;

   for (genvar w = 0; w < NUM_WORDS; w++) begin : g_word
      localparam logic [ADDR_WIDTH-1:0] WADDR = ADDR_WIDTH'(w);

      logic           en, en_l, wclk;
      logic [NB-1:0]  bwe;
      logic [NB-1:0][7:0] bdata;

      always_comb begin
         en = init_wr && (cnt_q == WADDR);
         for (int p = 0; p < NUM_WPORTS; p++) begin
            if (wreq[p] && (waddr_i[p] == WADDR)) en = 1'b1;
         end
      end

      always_latch begin
         if (!gclk) en_l = en | test_en_i;
      end

      assign wclk = gclk & en_l;

      // Ascending port order lets the highest-index port with its byte enabled win.
      always_comb begin
         bwe   = '0;
         bdata = '0;
         if (init_vld_p1 && (init_addr_p1 == WADDR)) bwe = '1;
         for (int p = 0; p < NUM_WPORTS; p++) begin
            for (int b = 0; b < NB; b++) begin
               if (wvld_p1[p] && (waddr_p1[p] == WADDR) && be_p1[p][b]) begin
                  bwe[b]   = 1'b1;
                  bdata[b] = wdata_p1[p][b*8 +: 8];
               end
            end
         end
      end

      for (genvar b = 0; b < NB; b++) begin : g_byte
         logic [7:0] q;
         always_latch begin
            if (wclk && bwe[b]) q = bdata[b];
         end
         assign mem[w][b*8 +: 8] = q;
      end
   end

   // Forwarded bytes come from stable p1 registers, so read data settles before the latch opens.
   always_comb begin
      rdata_o = '0;
      for (int r = 0; r < NUM_RPORTS; r++) begin
         if (ready && ({1'b0, raddr_p1[r]} < WORDS)) begin
            rdata_o[r] = mem[raddr_p1[r]];
            if (init_vld_p1 && (init_addr_p1 == raddr_p1[r])) rdata_o[r] = '0;
            for (int p = 0; p < NUM_WPORTS; p++) begin
               for (int b = 0; b < NB; b++) begin
                  if (wvld_p1[p] && (waddr_p1[p] == raddr_p1[r]) && be_p1[p][b]) begin
                     rdata_o[r][b*8 +: 8] = wdata_p1[p][b*8 +: 8];
                  end
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_register_file_nw_mr_latch.sv
// Self-checking bench: three register-file instances (32w 2W2R, 20w 2W2R, 48w 4W8R) checked
// against expected read data queued at stimulus time.
module tb_register_file_nw_mr_latch;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic test_en = 1'b0;
   int   n_checks = 0;
   int   n_fail   = 0;
   logic [31:0] exp_q[$];

   logic            rst_a, done_a;
   logic [1:0][4:0]  raddr_a, waddr_a;
   logic [1:0][31:0] rdata_a, wdata_a;
   logic [1:0]       we_a;
   logic [1:0][3:0]  be_a;

   logic            rst_b, done_b;
   logic [1:0][4:0]  raddr_b, waddr_b;
   logic [1:0][31:0] rdata_b, wdata_b;
   logic [1:0]       we_b;
   logic [1:0][3:0]  be_b;

   logic            rst_c, done_c;
   logic [7:0][5:0]  raddr_c;
   logic [7:0][31:0] rdata_c;
   logic [3:0]       we_c;
   logic [3:0][5:0]  waddr_c;
   logic [3:0][31:0] wdata_c;
   logic [3:0][3:0]  be_c;

   register_file_nw_mr_latch #(.NUM_WORDS(32), .DATA_WIDTH(32), .NUM_WPORTS(2), .NUM_RPORTS(2)) dut_a (
      .clk(clk), .rst(rst_a), .test_en_i(test_en), .init_done_o(done_a),
      .raddr_i(raddr_a), .rdata_o(rdata_a), .we_i(we_a), .waddr_i(waddr_a),
      .wdata_i(wdata_a), .be_i(be_a));

   register_file_nw_mr_latch #(.NUM_WORDS(20), .DATA_WIDTH(32), .NUM_WPORTS(2), .NUM_RPORTS(2)) dut_b (
      .clk(clk), .rst(rst_b), .test_en_i(test_en), .init_done_o(done_b),
      .raddr_i(raddr_b), .rdata_o(rdata_b), .we_i(we_b), .waddr_i(waddr_b),
      .wdata_i(wdata_b), .be_i(be_b));

   register_file_nw_mr_latch #(.NUM_WORDS(48), .DATA_WIDTH(32), .NUM_WPORTS(4), .NUM_RPORTS(8)) dut_c (
      .clk(clk), .rst(rst_c), .test_en_i(test_en), .init_done_o(done_c),
      .raddr_i(raddr_c), .rdata_o(rdata_c), .we_i(we_c), .waddr_i(waddr_c),
      .wdata_i(wdata_c), .be_i(be_c));

   typedef struct {
      logic [1:0]  we;
      logic [4:0]  a0;
      logic [31:0] d0;
      logic [3:0]  b0;
      logic [4:0]  a1;
      logic [31:0] d1;
      logic [3:0]  b1;
      logic [4:0]  r0;
      logic [4:0]  r1;
      logic [31:0] e0;
      logic [31:0] e1;
   } step_t;

   task automatic apply_step_a(input step_t s);
      we_a       = s.we;
      waddr_a[0] = s.a0;  wdata_a[0] = s.d0;  be_a[0] = s.b0;
      waddr_a[1] = s.a1;  wdata_a[1] = s.d1;  be_a[1] = s.b1;
      raddr_a[0] = s.r0;  raddr_a[1] = s.r1;
   endtask

   task automatic test_reset();
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         we_a = 2'b11; waddr_a[0] = 5'd3; waddr_a[1] = 5'd4;
         wdata_a = '1; be_a = '1; raddr_a[0] = 5'd3; raddr_a[1] = 5'd4;
         @(posedge clk); #1;
         n_checks++;
         if (done_a !== 1'b0) begin
            n_fail++; $display("FAIL reset_done cyc%0d: got %b want 0", k, done_a);
         end
         n_checks++;
         if (rdata_a !== '0) begin
            n_fail++; $display("FAIL reset_rdata cyc%0d: got %h want 0", k, rdata_a);
         end
      end
   endtask

   task automatic test_init_sweep();
      for (int k = 1; k <= 32; k++) begin
         @(negedge clk);
         if (k == 1) rst_a = 1'b0;
         if (k <= 4) begin
            we_a = 2'b11; waddr_a[0] = 5'd3; waddr_a[1] = 5'd3;
            wdata_a[0] = 32'hFFFF_FFFF; wdata_a[1] = 32'h1234_5678; be_a = '1;
         end else begin
            we_a = '0;
         end
         raddr_a[0] = 5'd3; raddr_a[1] = 5'(k);
         @(posedge clk); #1;
         n_checks++;
         if (done_a !== (k == 32)) begin
            n_fail++; $display("FAIL init_done edge%0d: got %b want %b", k, done_a, (k == 32));
         end
         n_checks++;
         if (rdata_a[0] !== 32'h0) begin
            n_fail++; $display("FAIL init_rdata edge%0d: got %h want 0", k, rdata_a[0]);
         end
      end
      for (int w = 0; w < 32; w++) begin
         @(negedge clk);
         we_a = '0; raddr_a[0] = 5'(w); raddr_a[1] = 5'(31 - w);
         exp_q.push_back(32'h0); exp_q.push_back(32'h0);
         @(posedge clk); #1;
         for (int r = 0; r < 2; r++) begin
            logic [31:0] e;
            e = exp_q.pop_front();
            n_checks++;
            if (rdata_a[r] !== e) begin
               n_fail++; $display("FAIL init_zero w%0d port%0d: got %h want %h", w, r, rdata_a[r], e);
            end
         end
      end
   endtask

   task automatic test_write_forward();
      step_t st[5];
      st[0] = '{2'b01, 5'd5, 32'hDEADBEEF, 4'hF, 5'd0, 32'h0, 4'h0, 5'd5, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF};
      st[1] = '{2'b00, 5'd0, 32'h0,        4'h0, 5'd0, 32'h0, 4'h0, 5'd5, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF};
      st[2] = '{2'b01, 5'd5, 32'h12345678, 4'h0, 5'd0, 32'h0, 4'h0, 5'd5, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF};
      st[3] = '{2'b01, 5'd5, 32'h00AB0000, 4'h4, 5'd0, 32'h0, 4'h0, 5'd5, 5'd5, 32'hDEABBEEF, 32'hDEABBEEF};
      st[4] = '{2'b00, 5'd0, 32'h0,        4'h0, 5'd0, 32'h0, 4'h0, 5'd5, 5'd5, 32'hDEABBEEF, 32'hDEABBEEF};
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         apply_step_a(st[i]);
         exp_q.push_back(st[i].e0); exp_q.push_back(st[i].e1);
         @(posedge clk); #1;
         for (int r = 0; r < 2; r++) begin
            logic [31:0] e;
            e = exp_q.pop_front();
            n_checks++;
            if (rdata_a[r] !== e) begin
               n_fail++; $display("FAIL fwd step%0d port%0d: got %h want %h", i, r, rdata_a[r], e);
            end
         end
      end
   endtask

   task automatic test_conflict();
      step_t st[4];
      st[0] = '{2'b11, 5'd7, 32'h11111111, 4'hF, 5'd7, 32'h22222222, 4'h3, 5'd7, 5'd7, 32'h11112222, 32'h11112222};
      st[1] = '{2'b00, 5'd0, 32'h0,        4'h0, 5'd0, 32'h0,        4'h0, 5'd7, 5'd7, 32'h11112222, 32'h11112222};
      st[2] = '{2'b11, 5'd8, 32'hAAAAAAAA, 4'hF, 5'd8, 32'hBBBBBBBB, 4'hF, 5'd8, 5'd7, 32'hBBBBBBBB, 32'h11112222};
      st[3] = '{2'b00, 5'd0, 32'h0,        4'h0, 5'd0, 32'h0,        4'h0, 5'd8, 5'd8, 32'hBBBBBBBB, 32'hBBBBBBBB};
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         apply_step_a(st[i]);
         exp_q.push_back(st[i].e0); exp_q.push_back(st[i].e1);
         @(posedge clk); #1;
         for (int r = 0; r < 2; r++) begin
            logic [31:0] e;
            e = exp_q.pop_front();
            n_checks++;
            if (rdata_a[r] !== e) begin
               n_fail++; $display("FAIL conflict step%0d port%0d: got %h want %h", i, r, rdata_a[r], e);
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      step_t st[5];
      st[0] = '{2'b01, 5'd9,  32'hA0A0A0A0, 4'hF, 5'd0,  32'h0,        4'h0, 5'd9,  5'd9,  32'hA0A0A0A0, 32'hA0A0A0A0};
      st[1] = '{2'b10, 5'd0,  32'h0,        4'h0, 5'd9,  32'h000000FF, 4'h1, 5'd9,  5'd9,  32'hA0A0A0FF, 32'hA0A0A0FF};
      st[2] = '{2'b11, 5'd10, 32'h00000001, 4'hF, 5'd11, 32'hCAFEF00D, 4'hF, 5'd9,  5'd10, 32'hA0A0A0FF, 32'h00000001};
      st[3] = '{2'b01, 5'd11, 32'h00000000, 4'h8, 5'd0,  32'h0,        4'h0, 5'd11, 5'd10, 32'h00FEF00D, 32'h00000001};
      st[4] = '{2'b00, 5'd0,  32'h0,        4'h0, 5'd0,  32'h0,        4'h0, 5'd11, 5'd9,  32'h00FEF00D, 32'hA0A0A0FF};
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         apply_step_a(st[i]);
         exp_q.push_back(st[i].e0); exp_q.push_back(st[i].e1);
         @(posedge clk); #1;
         for (int r = 0; r < 2; r++) begin
            logic [31:0] e;
            e = exp_q.pop_front();
            n_checks++;
            if (rdata_a[r] !== e) begin
               n_fail++; $display("FAIL b2b step%0d port%0d: got %h want %h", i, r, rdata_a[r], e);
            end
         end
      end
   endtask

   task automatic test_out_of_range();
      int k;
      @(negedge clk);
      rst_b = 1'b0;
      k = 0;
      while (done_b !== 1'b1 && k < 100) begin
         @(posedge clk); #1; k++;
      end
      n_checks++;
      if (k != 20) begin
         n_fail++; $display("FAIL b_init_latency: got %0d edges want 20", k);
      end
      for (int w = 0; w < 20; w++) begin
         @(negedge clk);
         we_b = 2'b01; waddr_b[0] = 5'(w); wdata_b[0] = 32'h0B00_0000 | 32'(w); be_b[0] = 4'hF;
      end
      @(negedge clk);
      we_b = 2'b11;
      waddr_b[0] = 5'd25; wdata_b[0] = 32'hAAAA_5555; be_b[0] = 4'hF;
      waddr_b[1] = 5'd20; wdata_b[1] = 32'h5555_AAAA; be_b[1] = 4'hF;
      raddr_b[0] = 5'd25; raddr_b[1] = 5'd19;
      exp_q.push_back(32'h0); exp_q.push_back(32'h0B00_0013);
      @(posedge clk); #1;
      for (int r = 0; r < 2; r++) begin
         logic [31:0] e;
         e = exp_q.pop_front();
         n_checks++;
         if (rdata_b[r] !== e) begin
            n_fail++; $display("FAIL oor_write port%0d: got %h want %h", r, rdata_b[r], e);
         end
      end
      for (int w = 0; w < 23; w++) begin
         int a;
         a = (w < 20) ? w : (w == 20) ? 20 : (w == 21) ? 25 : 31;
         @(negedge clk);
         we_b = '0; raddr_b[0] = 5'(a); raddr_b[1] = 5'(a);
         exp_q.push_back((a < 20) ? (32'h0B00_0000 | 32'(a)) : 32'h0);
         @(posedge clk); #1;
         begin
            logic [31:0] e;
            e = exp_q.pop_front();
            n_checks++;
            if (rdata_b[0] !== e || rdata_b[1] !== e) begin
               n_fail++; $display("FAIL oor_readback addr%0d: got %h/%h want %h", a, rdata_b[0], rdata_b[1], e);
            end
         end
      end
   endtask

   task automatic test_reset_mid_init();
      for (int w = 0; w < 32; w++) begin
         @(negedge clk);
         we_a = 2'b01; waddr_a[0] = 5'(w); wdata_a[0] = 32'h5A5A_0000 | 32'(w); be_a[0] = 4'hF;
      end
      @(negedge clk);
      we_a = '0; raddr_a[0] = 5'd12; raddr_a[1] = 5'd30;
      exp_q.push_back(32'h5A5A_000C); exp_q.push_back(32'h5A5A_001E);
      @(posedge clk); #1;
      for (int r = 0; r < 2; r++) begin
         logic [31:0] e;
         e = exp_q.pop_front();
         n_checks++;
         if (rdata_a[r] !== e) begin
            n_fail++; $display("FAIL t5_prewrite port%0d: got %h want %h", r, rdata_a[r], e);
         end
      end
      @(negedge clk); rst_a = 1'b1;
      @(negedge clk); rst_a = 1'b0;
      repeat (10) @(posedge clk);
      @(negedge clk); rst_a = 1'b1;
      @(negedge clk); rst_a = 1'b0;
      for (int k = 1; k <= 32; k++) begin
         @(posedge clk); #1;
         n_checks++;
         if (done_a !== (k == 32)) begin
            n_fail++; $display("FAIL t5_done edge%0d: got %b want %b", k, done_a, (k == 32));
         end
      end
      for (int w = 0; w < 32; w++) begin
         @(negedge clk);
         raddr_a[0] = 5'(w); raddr_a[1] = 5'(31 - w);
         exp_q.push_back(32'h0); exp_q.push_back(32'h0);
         @(posedge clk); #1;
         for (int r = 0; r < 2; r++) begin
            logic [31:0] e;
            e = exp_q.pop_front();
            n_checks++;
            if (rdata_a[r] !== e) begin
               n_fail++; $display("FAIL t5_zero w%0d port%0d: got %h want %h", w, r, rdata_a[r], e);
            end
         end
      end
   endtask

   task automatic test_random();
      logic [31:0] model [48];
      int k;
      int shown;
      for (int w = 0; w < 48; w++) model[w] = 32'h0;
      @(negedge clk);
      rst_c = 1'b0;
      k = 0;
      while (done_c !== 1'b1 && k < 200) begin
         @(posedge clk); #1; k++;
      end
      n_checks++;
      if (k != 48) begin
         n_fail++; $display("FAIL c_init_latency: got %0d edges want 48", k);
      end
      shown = 0;
      for (int cyc = 0; cyc < 10000; cyc++) begin
         @(negedge clk);
         for (int p = 0; p < 4; p++) begin
            we_c[p]    = ($urandom_range(0, 9) < 6);
            waddr_c[p] = 6'($urandom_range(0, 55));
            wdata_c[p] = $urandom;
            be_c[p]    = 4'($urandom_range(0, 15));
         end
         for (int r = 0; r < 8; r++) begin
            if ($urandom_range(0, 3) == 0) begin
               int pi;
               pi = int'($urandom_range(0, 3));
               raddr_c[r] = waddr_c[pi];
            end else begin
               raddr_c[r] = 6'($urandom_range(0, 55));
            end
         end
         for (int p = 0; p < 4; p++) begin
            int a;
            a = int'(waddr_c[p]);
            if (we_c[p] && a < 48) begin
               for (int b = 0; b < 4; b++) begin
                  if (be_c[p][b]) model[a][8*b +: 8] = wdata_c[p][8*b +: 8];
               end
            end
         end
         for (int r = 0; r < 8; r++) begin
            int a;
            a = int'(raddr_c[r]);
            exp_q.push_back((a < 48) ? model[a] : 32'h0);
         end
         @(posedge clk); #1;
         for (int r = 0; r < 8; r++) begin
            logic [31:0] e;
            e = exp_q.pop_front();
            n_checks++;
            if (rdata_c[r] !== e) begin
               n_fail++;
               if (shown < 20) begin
                  shown++;
                  $display("FAIL rand cyc%0d port%0d addr%0d: got %h want %h", cyc, r, raddr_c[r], rdata_c[r], e);
               end
            end
         end
      end
      @(negedge clk);
      we_c = '0;
   endtask

   initial begin
      rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
      raddr_a = '0; waddr_a = '0; wdata_a = '0; we_a = '0; be_a = '0;
      raddr_b = '0; waddr_b = '0; wdata_b = '0; we_b = '0; be_b = '0;
      raddr_c = '0; waddr_c = '0; wdata_c = '0; we_c = '0; be_c = '0;
      test_reset();
      test_init_sweep();
      test_write_forward();
      test_conflict();
      test_back_to_back();
      test_out_of_range();
      test_reset_mid_init();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
